// File: rtl/rgb_fader.sv
// rtl/rgb_fader.sv - RGB LED effect generator: colour wheel, breathe and hold with three PWM channels
//
// Ports:
//   clk    - system clock
//   rst    - asynchronous reset, active-high
//   en     - 1 advances the effect; 0 freezes position/level (PWM keeps running)
//   mode   - 0 wheel, 1 breathe, 2/3 hold
//   color  - {r,g,b} duty source for breathe/hold, sampled on each step tick
//   red    - PWM output, red
//   green  - PWM output, green
//   blue   - PWM output, blue
//   wrap   - one-cycle pulse when the wheel wraps or the breathe level returns to 0
module rgb_fader #(
   parameter int PWM_BITS = 8,
   parameter int DIV_MAX  = 50000,
   parameter int STEP     = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [1:0]              mode,
   input  logic [3*PWM_BITS-1:0]   color,
   output logic                    red,
   output logic                    green,
   output logic                    blue,
   output logic                    wrap
);

   localparam int MAX   = 2**PWM_BITS - 1;
   localparam int PW    = PWM_BITS + 2;
   localparam int PRW   = 2 * PWM_BITS;
   localparam int DIV_W = $clog2(DIV_MAX + 1);

   localparam logic [PW-1:0]       MAX_1   = PW'(MAX);
   localparam logic [PW-1:0]       MAX_2   = PW'(2 * MAX);
   localparam logic [PW-1:0]       MAX_3   = PW'(3 * MAX);
   localparam logic [PW-1:0]       STEP_W  = PW'(STEP);
   localparam logic [DIV_W-1:0]    DIV_END = DIV_W'(DIV_MAX);
   localparam logic [PWM_BITS-1:0] CNT_END = PWM_BITS'(MAX - 1);

   logic [DIV_W-1:0]    div_q, div_d;
   logic [PW-1:0]       pos_q, pos_d;
   logic [PWM_BITS-1:0] level_q, level_d;
   logic                dir_down_q, dir_down_d;
   logic [1:0]          mode_q, mode_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_BITS-1:0] r_duty_q, r_duty_d;
   logic [PWM_BITS-1:0] g_duty_q, g_duty_d;
   logic [PWM_BITS-1:0] b_duty_q, b_duty_d;
   logic                red_q, red_d;
   logic                green_q, green_d;
   logic                blue_q, blue_d;
   logic                wrap_q, wrap_d;

   logic                tick;
   logic [PW-1:0]       wh_r, wh_g, wh_b;
   logic [PW-1:0]       pos_sum, lvl_sum;
   logic [PWM_BITS-1:0] col_r, col_g, col_b;

   assign col_r = color[3*PWM_BITS-1:2*PWM_BITS];
   assign col_g = color[2*PWM_BITS-1:PWM_BITS];
   assign col_b = color[PWM_BITS-1:0];

   // Wheel duties from the current position; adjacent channels always sum to MAX.
   always_comb begin
      wh_r = '0;
      wh_g = '0;
      wh_b = '0;
      if (pos_q < MAX_1) begin
         wh_r = MAX_1 - pos_q;
         wh_b = pos_q;
      end else if (pos_q < MAX_2) begin
         wh_g = pos_q - MAX_1;
         wh_b = MAX_2 - pos_q;
      end else begin
         wh_r = pos_q - MAX_2;
         wh_g = MAX_3 - pos_q;
      end
   end

   always_comb begin
      div_d      = div_q;
      pos_d      = pos_q;
      level_d    = level_q;
      dir_down_d = dir_down_q;
      mode_d     = mode;
      r_duty_d   = r_duty_q;
      g_duty_d   = g_duty_q;
      b_duty_d   = b_duty_q;
      wrap_d     = 1'b0;
      tick       = 1'b0;
      pos_sum    = pos_q + STEP_W;
      lvl_sum    = PW'(level_q) + STEP_W;

      // A mode change restarts the effect and swallows any tick in that cycle.
      if (mode != mode_q) begin
         div_d      = '0;
         pos_d      = '0;
         level_d    = '0;
         dir_down_d = 1'b0;
      end else if (en) begin
         if (div_q == DIV_END) begin
            div_d = '0;
            tick  = 1'b1;
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end

      // Duties reflect the position/level held at the tick; the state then advances.
      if (tick) begin
         case (mode_q)
            2'd0: begin
               r_duty_d = PWM_BITS'(wh_r);
               g_duty_d = PWM_BITS'(wh_g);
               b_duty_d = PWM_BITS'(wh_b);
               if (pos_sum >= MAX_3) begin
                  pos_d  = pos_sum - MAX_3;
                  wrap_d = 1'b1;
               end else begin
                  pos_d = pos_sum;
               end
            end
            2'd1: begin
               r_duty_d = PWM_BITS'((PRW'(col_r) * PRW'(level_q)) >> PWM_BITS);
               g_duty_d = PWM_BITS'((PRW'(col_g) * PRW'(level_q)) >> PWM_BITS);
               b_duty_d = PWM_BITS'((PRW'(col_b) * PRW'(level_q)) >> PWM_BITS);
               if (!dir_down_q) begin
                  if (lvl_sum >= MAX_1) begin
                     level_d    = PWM_BITS'(MAX);
                     dir_down_d = 1'b1;
                  end else begin
                     level_d = PWM_BITS'(lvl_sum);
                  end
               end else begin
                  if (PW'(level_q) <= STEP_W) begin
                     level_d    = '0;
                     dir_down_d = 1'b0;
                     wrap_d     = 1'b1;
                  end else begin
                     level_d = level_q - PWM_BITS'(STEP);
                  end
               end
            end
            default: begin
               r_duty_d = col_r;
               g_duty_d = col_g;
               b_duty_d = col_b;
            end
         endcase
      end

      // Free-running PWM frame of MAX clocks, independent of en.
      pwm_cnt_d = (pwm_cnt_q == CNT_END) ? '0 : pwm_cnt_q + PWM_BITS'(1);
      red_d     = (pwm_cnt_q < r_duty_q);
      green_d   = (pwm_cnt_q < g_duty_q);
      blue_d    = (pwm_cnt_q < b_duty_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q      <= '0;
         pos_q      <= '0;
         level_q    <= '0;
         dir_down_q <= 1'b0;
         mode_q     <= '0;
         pwm_cnt_q  <= '0;
         r_duty_q   <= '0;
         g_duty_q   <= '0;
         b_duty_q   <= '0;
         red_q      <= 1'b0;
         green_q    <= 1'b0;
         blue_q     <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         div_q      <= div_d;
         pos_q      <= pos_d;
         level_q    <= level_d;
         dir_down_q <= dir_down_d;
         mode_q     <= mode_d;
         pwm_cnt_q  <= pwm_cnt_d;
         r_duty_q   <= r_duty_d;
         g_duty_q   <= g_duty_d;
         b_duty_q   <= b_duty_d;
         red_q      <= red_d;
         green_q    <= green_d;
         blue_q     <= blue_d;
         wrap_q     <= wrap_d;
      end
   end

   assign red   = red_q;
   assign green = green_q;
   assign blue  = blue_q;
   assign wrap  = wrap_q;

endmodule
